spi_rom_line_streamer: RTL and testbench

Parametrised SPI flash line fetcher that succeeds the fixed-timing VGA SPI ROM demo. On a `start` request it issues a READ command with a caller-supplied address, then streams `BUFFER_DEPTH` bits from MISO into one bank of a ping-pong line buffer. The display side reads the other bank by bit index. It sits between the VGA timing logic, which decides when to fetch and which address, and the off-chip SPI ROM.

---
 rtl/spi_rom_line_streamer.sv | 193 +++++++++++++++++++
 tb/tb_spi_rom_line_streamer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rom_line_streamer.sv
`default_nettype none
//==============================================================================
// Module   : spi_rom_line_streamer
// Brief    : SPI flash line fetcher that streams BUFFER_DEPTH bits into one
//            bank of a ping-pong bit buffer. Define SPI_ROM_STREAMER_FAST_READ_EN
//            for FAST READ (0x0B, 8 dummy cycles).
// Revision : 1.0  initial release
//==============================================================================
module spi_rom_line_streamer #(
    parameter  int BUFFER_DEPTH = 256,
    parameter  int ADDR_LEN     = 24,
    localparam int IDX_W        = $clog2(BUFFER_DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_LEN-1:0] start_addr,
    input  logic                swap,
    input  logic [IDX_W-1:0]    rd_index,
    output logic                rd_data,
    output logic                busy,
    output logic                done,
    output logic                stream_valid,
    output logic                stream_data,
    output logic                spi_cs,
    output logic                spi_sclk,
    output logic                spi_mosi,
    input  logic                spi_miso
);

    localparam int c_hdr_len = 8 + ADDR_LEN;
    localparam int c_max_len = (BUFFER_DEPTH > ADDR_LEN) ? BUFFER_DEPTH : ADDR_LEN;
    localparam int c_cnt_w   = $clog2(c_max_len);

`ifdef SPI_ROM_STREAMER_FAST_READ_EN
    localparam logic [7:0] c_cmd       = 8'h0B;
    localparam bit         c_use_dummy = 1'b1;
`else
    localparam logic [7:0] c_cmd       = 8'h03;
    localparam bit         c_use_dummy = 1'b0;
`endif

    localparam logic [c_cnt_w-1:0] c_last_byte = c_cnt_w'(7);
    localparam logic [c_cnt_w-1:0] c_last_addr = c_cnt_w'(ADDR_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_last_data = c_cnt_w'(BUFFER_DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_ADDR  = 3'd2,
        S_DUMMY = 3'd3,
        S_DATA  = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [c_cnt_w-1:0]      w_cnt_next;
    logic                    w_accept;
    logic                    w_data_last;

    logic [c_hdr_len-1:0]    r_shift;
    logic                    r_fill_bank;
    logic                    r_disp_bank;
    logic                    r_swap_pend;
    logic                    r_done;
    logic                    r_stream_valid;
    logic                    r_stream_data;
    logic                    r_miso_q;
    logic [BUFFER_DEPTH-1:0] r_bank [2];

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + c_one;
        w_accept     = 1'b0;
        w_data_last  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_CMD;
                end
            end
            S_CMD: begin
                if (r_cnt == c_last_byte) begin
                    w_state_next = S_ADDR;
                    w_cnt_next   = '0;
                end
            end
            S_ADDR: begin
                if (r_cnt == c_last_addr) begin
                    if (c_use_dummy) begin
                        w_state_next = S_DUMMY;
                    end else begin
                        w_state_next = S_DATA;
                    end
                    w_cnt_next = '0;
                end
            end
            S_DUMMY: begin
                if (r_cnt == c_last_byte) begin
                    w_state_next = S_DATA;
                    w_cnt_next   = '0;
                end
            end
            S_DATA: begin
                if (r_cnt == c_last_data) begin
                    w_data_last  = 1'b1;
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift        <= '0;
            r_fill_bank    <= 1'b0;
            r_disp_bank    <= 1'b0;
            r_swap_pend    <= 1'b0;
            r_done         <= 1'b0;
            r_stream_valid <= 1'b0;
            r_stream_data  <= 1'b0;
        end else begin
            r_done         <= w_data_last;
            r_stream_valid <= (r_state == S_DATA);
            if (r_state == S_DATA) begin
                r_stream_data <= r_miso_q;
            end

            // Command and address are shifted out of one register, MSB first.
            if (w_accept) begin
                r_shift     <= {c_cmd, start_addr};
                r_fill_bank <= ~r_disp_bank;
            end else if (r_state == S_CMD || r_state == S_ADDR) begin
                r_shift <= {r_shift[c_hdr_len-2:0], 1'b0};
            end

            // A swap landing on the final data cycle is honoured together with the pending one.
            if (w_data_last) begin
                if (r_swap_pend || swap) begin
                    r_disp_bank <= ~r_disp_bank;
                end
                r_swap_pend <= 1'b0;
            end else if (swap) begin
                if (r_state != S_IDLE) begin
                    r_swap_pend <= 1'b1;
                end else begin
                    r_disp_bank <= ~r_disp_bank;
                end
            end
        end
    end

    // MISO is sampled on the rising spi_sclk edge, which is the falling clk edge.
    always_ff @(negedge clk) begin
        r_miso_q <= spi_miso;
    end

    always_ff @(posedge clk) begin
        if (r_state == S_DATA) begin
            r_bank[r_fill_bank][r_cnt[IDX_W-1:0]] <= r_miso_q;
        end
    end

    assign spi_cs       = (r_state != S_IDLE);
    assign busy         = spi_cs;
    assign done         = r_done;
    assign stream_valid = r_stream_valid;
    assign stream_data  = r_stream_data;
    assign spi_sclk     = ~clk;
    assign spi_mosi     = (r_state == S_CMD || r_state == S_ADDR) ? r_shift[c_hdr_len-1] : 1'b0;
    assign rd_data      = r_bank[r_disp_bank][rd_index];

endmodule
`default_nettype wire

// File: tb/tb_spi_rom_line_streamer.sv
`default_nettype none
//==============================================================================
// Module   : tb_spi_rom_line_streamer
// Brief    : Directed self-checking bench with a behavioural SPI flash and a
//            stream scoreboard. Honours SPI_ROM_STREAMER_FAST_READ_EN.
// Revision : 1.0  initial release
//==============================================================================
module tb_spi_rom_line_streamer;

    localparam int c_depth = 256;
    localparam int c_alen  = 24;
    localparam int c_hdr   = 8 + c_alen;
`ifdef SPI_ROM_STREAMER_FAST_READ_EN
    localparam logic [7:0] c_cmd   = 8'h0B;
    localparam int         c_dummy = 8;
`else
    localparam logic [7:0] c_cmd   = 8'h03;
    localparam int         c_dummy = 0;
`endif
    localparam int c_cs_len = c_hdr + c_dummy + c_depth;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [c_alen-1:0] start_addr;
    logic              swap;
    logic [7:0]        rd_index;
    logic              rd_data;
    logic              busy;
    logic              done;
    logic              stream_valid;
    logic              stream_data;
    logic              spi_cs;
    logic              spi_sclk;
    logic              spi_mosi;
    logic              spi_miso = 1'b0;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic       sb[$];
    logic [7:0] flash_byte = 8'h00;
    int         fcyc = 0;
    int         j;
    int         cs_run = 0;
    int         last_cs_len = 0;
    int         done_cnt = 0;
    int         mosi_bad = 0;
    logic [c_hdr-1:0] cap_hdr = '0;
    logic       exp_b;

    spi_rom_line_streamer #(
        .BUFFER_DEPTH (c_depth),
        .ADDR_LEN     (c_alen)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .start_addr   (start_addr),
        .swap         (swap),
        .rd_index     (rd_index),
        .rd_data      (rd_data),
        .busy         (busy),
        .done         (done),
        .stream_valid (stream_valid),
        .stream_data  (stream_data),
        .spi_cs       (spi_cs),
        .spi_sclk     (spi_sclk),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Flash: presents data bit j of the repeating byte, MSB first, and records it.
    always @(posedge clk) begin
        #1;
        if (spi_cs) begin
            if (fcyc >= c_hdr + c_dummy) begin
                j = fcyc - c_hdr - c_dummy;
                spi_miso = flash_byte[7 - (j % 8)];
                sb.push_back(spi_miso);
            end else begin
                spi_miso = 1'b0;
            end
            fcyc++;
        end else begin
            fcyc = 0;
            spi_miso = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (stream_valid) begin
            if (sb.size() == 0) begin
                check("stream_without_bit", stream_valid, 1'b0);
            end else begin
                exp_b = sb.pop_front();
                check("stream_data", stream_data, exp_b);
            end
        end
        if (done) done_cnt++;
        if (spi_cs) begin
            if (cs_run < c_hdr) cap_hdr = {cap_hdr[c_hdr-2:0], spi_mosi};
            else if (spi_mosi !== 1'b0) mosi_bad++;
            cs_run++;
        end else begin
            if (spi_mosi !== 1'b0) mosi_bad++;
            if (cs_run != 0) begin
                last_cs_len = cs_run;
                cs_run = 0;
            end
        end
    end

    task automatic do_start(input logic [c_alen-1:0] addr);
        @(negedge clk);
        start_addr = addr;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_swap();
        @(negedge clk);
        swap = 1'b1;
        @(negedge clk);
        swap = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic read_check(input string tag, input int idx, input logic exp);
        @(negedge clk);
        rd_index = idx[7:0];
        #1;
        check(tag, rd_data, exp);
    endtask

    initial begin
        bit         ok;
        int         bad;
        int         d0;
        logic [7:0] pat;

        reset = 1'b1; start = 1'b0; start_addr = '0; swap = 1'b0; rd_index = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state and idle behaviour
        @(negedge clk);
        check("rst_cs", spi_cs, 1'b0);
        check("rst_mosi", spi_mosi, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_valid", stream_valid, 1'b0);
        check("rst_sdata", stream_data, 1'b0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({spi_cs, spi_mosi, busy, done, stream_valid} !== 5'b0) bad++;
            if (spi_sclk !== 1'b1) bad++;
            @(posedge clk);
            #1;
            if (spi_sclk !== 1'b0) bad++;
        end
        check("idle_quiet_sclk", bad, 0);

        // First fetch: 0xA5 into bank 1
        flash_byte = 8'hA5;
        do_start(24'h000470);
        check("f1_cs_after_start", spi_cs, 1'b1);
        check("f1_busy_eq_cs", busy, 1'b1);
        wait_done(ok);
        check("f1_done_seen", ok, 1'b1);
        check("f1_cs_low_at_done", spi_cs, 1'b0);
        @(negedge clk);
        check("f1_done_one_cycle", done, 1'b0);
        check("f1_done_count", done_cnt, 1);
        check("f1_cs_len", last_cs_len, c_cs_len);
        check("f1_header", cap_hdr, {c_cmd, 24'h000470});
        check("f1_mosi_idle_zero", mosi_bad, 0);
        do_swap();
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) read_check("f1_rd_bit", i, pat[7-i]);

        // Ping-pong: bank1 = 0xFF displayed while bank0 fills with 0x00
        do_swap();
        flash_byte = 8'hFF;
        do_start(24'h000100);
        wait_done(ok);
        check("pp_fill1_done", ok, 1'b1);
        do_swap();
        flash_byte = 8'h00;
        do_start(24'h000200);
        bad = 0; ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
            rd_index = 8'($urandom_range(0, c_depth - 1));
            #1;
            if (rd_data !== 1'b1) bad++;
        end
        check("pp_fill0_done", ok, 1'b1);
        check("pp_display_stable", bad, 0);
        do_swap();
        read_check("pp_bank0_idx0", 0, 1'b0);
        read_check("pp_bank0_idx100", 100, 1'b0);
        read_check("pp_bank0_idx255", 255, 1'b0);

        // Swap while busy: pending until done, second swap ignored
        flash_byte = 8'h3C;
        rd_index = 8'd2;
        do_start(24'h000300);
        bad = 0; ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (rd_data !== 1'b0) bad++;
            swap = (c == 100 || c == 130);
        end
        swap = 1'b0;
        check("sw_done_seen", ok, 1'b1);
        check("sw_no_early_toggle", bad, 0);
        check("sw_toggle_at_done", rd_data, 1'b1);
        read_check("sw_idx0", 0, 1'b0);
        read_check("sw_idx5", 5, 1'b1);

        // Reset mid-fetch aborts without done
        flash_byte = 8'h81;
        do_start(24'h000400);
        repeat (100) @(negedge clk);
        d0 = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        check("abort_cs", spi_cs, 1'b0);
        check("abort_busy", busy, 1'b0);
        reset = 1'b0;
        sb.delete();
        repeat (300) @(negedge clk);
        check("abort_no_done", done_cnt, d0);

        // Restart, then back-to-back start in the done cycle
        do_start(24'h000020);
        check("re_cs_after_start", spi_cs, 1'b1);
        wait_done(ok);
        check("re_done_seen", ok, 1'b1);
        start_addr = 24'hABCDEF;
        start = 1'b1;
        flash_byte = 8'h5A;
        @(negedge clk);
        start = 1'b0;
        check("b2b_no_gap", spi_cs, 1'b1);
        check("re_cs_len", last_cs_len, c_cs_len);
        wait_done(ok);
        check("b2b_done_seen", ok, 1'b1);
        @(negedge clk);
        check("b2b_cs_len", last_cs_len, c_cs_len);
        check("b2b_header", cap_hdr, {c_cmd, 24'hABCDEF});
        check("b2b_done_count", done_cnt, d0 + 2);
        do_swap();
        pat = 8'h5A;
        for (int i = 0; i < 4; i++) read_check("b2b_rd_bit", i, pat[7-i]);

        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        check("mosi_zero_outside_hdr", mosi_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
